act_arbiter: RTL and testbench

//  Round-robin arbiter sharing one pipelined activation unit among N_REQ requesters.
//  - Typical unit: ReLU, or any fixed-latency unit with no backpressure.
//  - Sits between the layer engines (requesters) and the activation stage.
//  - Tags each issued vector so the result is routed back to the requester that sent it.
//  - Responses carry no backpressure; requesters must accept them.

---
 rtl/act_arbiter.sv | 175 +++++++++++++++++
 tb/tb_act_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/act_arbiter.sv
// Round-robin arbiter sharing one fixed-latency activation unit among N_REQ requesters.
// Issued beats are tagged so each result is routed back to the requester that sent it.
module act_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 128,
  parameter int N_REQ      = 4,
  parameter int ACT_LAT    = 1,
  parameter int MAX_BURST  = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [N_REQ-1:0]                    req_vld,
  input  logic [N_REQ-1:0]                    req_last,
  input  logic [N_REQ*CH_NUM*DATA_WIDTH-1:0]  req_data,
  output logic [N_REQ-1:0]                    req_rdy,
  output logic                                act_vld,
  output logic [CH_NUM*DATA_WIDTH-1:0]        act_data,
  input  logic                                act_res_vld,
  input  logic [CH_NUM*DATA_WIDTH-1:0]        act_res_data,
  output logic [N_REQ-1:0]                    rsp_vld,
  output logic                                rsp_last,
  output logic [CH_NUM*DATA_WIDTH-1:0]        rsp_data,
  output logic [$clog2(N_REQ)-1:0]            grant_id,
  output logic                                busy,
  output logic                                err_orphan
);
  localparam int VW  = CH_NUM * DATA_WIDTH;
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_BURST) + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic           last;
  } tag_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [CW-1:0]  r_cnt;
  logic           r_act_vld;
  logic           r_act_last;
  logic [IDW-1:0] r_act_id;
  logic [VW-1:0]  r_act_data;
  tag_t           r_tag [ACT_LAT];
  logic [N_REQ-1:0] r_rsp_vld;
  logic           r_rsp_last;
  logic [VW-1:0]  r_rsp_data;
  logic           r_err;

  logic [VW-1:0]  w_req_vec [N_REQ];
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_next_ptr;
  logic           w_acc;
  logic           w_release;
  logic           w_inflight;
  tag_t           w_tag;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_req_vec[gi] = req_data[gi*VW +: VW];
      assign req_rdy[gi]   = (r_state == S_GRANT) && (r_grant_id == IDW'(gi));
    end
  endgenerate

  // Lowest offset from the pointer wins, so scan offsets from high to low.
  always_comb begin
    logic [IDW:0] v_idx;
    w_pick = r_ptr;
    v_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (v_idx >= (IDW+1)'(N_REQ)) v_idx = v_idx - (IDW+1)'(N_REQ);
      if (req_vld[v_idx[IDW-1:0]]) w_pick = v_idx[IDW-1:0];
    end
  end

  assign w_acc      = (r_state == S_GRANT) && req_vld[r_grant_id];
  assign w_release  = w_acc && (req_last[r_grant_id] || (r_cnt == CW'(MAX_BURST - 1)));
  assign w_next_ptr = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_vld) begin
            r_grant_id <= w_pick;
            r_cnt      <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_release) begin
              r_state <= S_IDLE;
              r_ptr   <= w_next_ptr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_vld  <= 1'b0;
      r_act_last <= 1'b0;
      r_act_id   <= '0;
      r_act_data <= '0;
    end else begin
      r_act_vld <= w_acc;
      if (w_acc) begin
        r_act_data <= w_req_vec[r_grant_id];
        r_act_id   <= r_grant_id;
        r_act_last <= req_last[r_grant_id];
      end
    end
  end

  // Tag pipe mirrors the activation unit latency; its tail lines up with act_res_vld.
  generate
    for (gi = 0; gi < ACT_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) r_tag[gi] <= '0;
          else          r_tag[gi] <= '{v: r_act_vld, id: r_act_id, last: r_act_last};
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) r_tag[gi] <= '0;
          else          r_tag[gi] <= r_tag[gi-1];
        end
      end
    end
  endgenerate

  assign w_tag = r_tag[ACT_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_vld  <= '0;
      r_rsp_last <= 1'b0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rsp_vld  <= (act_res_vld && w_tag.v) ? (N_REQ'(1) << w_tag.id) : '0;
      r_rsp_last <= act_res_vld && w_tag.v && w_tag.last;
      r_rsp_data <= act_res_data;
      if (act_res_vld != w_tag.v) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_inflight = r_act_vld;
    for (int i = 0; i < ACT_LAT; i++) w_inflight = w_inflight | r_tag[i].v;
  end

  assign act_vld    = r_act_vld;
  assign act_data   = r_act_data;
  assign rsp_vld    = r_rsp_vld;
  assign rsp_last   = r_rsp_last;
  assign rsp_data   = r_rsp_data;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == S_GRANT) || w_inflight;
  assign err_orphan = r_err;
endmodule

// File: tb/tb_act_arbiter.sv
// Bench for act_arbiter: a ReLU activation unit model plus a transaction-level
// round-robin reference that predicts grant order, routing and response timing.
module tb_act_arbiter;
  localparam int DW  = 8;
  localparam int CH  = 128;
  localparam int NR  = 4;
  localparam int AL  = 4;
  localparam int MB  = 8;
  localparam int VW  = DW * CH;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [NR-1:0]    req_vld, req_last, req_rdy, rsp_vld;
  logic [NR*VW-1:0] req_data;
  logic             act_vld, act_res_vld, rsp_last, busy, err_orphan;
  logic [VW-1:0]    act_data, act_res_data, rsp_data;
  logic [IDW-1:0]   grant_id;

  act_arbiter #(.DATA_WIDTH(DW), .CH_NUM(CH), .N_REQ(NR), .ACT_LAT(AL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_vld(req_vld), .req_last(req_last), .req_data(req_data), .req_rdy(req_rdy),
    .act_vld(act_vld), .act_data(act_data),
    .act_res_vld(act_res_vld), .act_res_data(act_res_data),
    .rsp_vld(rsp_vld), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .grant_id(grant_id), .busy(busy), .err_orphan(err_orphan)
  );

  function automatic logic [VW-1:0] relu(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = v[c*DW + DW - 1] ? '0 : v[c*DW +: DW];
    return r;
  endfunction

  // Activation unit: AL-cycle ReLU pipe, plus an injection hook for orphan results.
  logic          inj = 1'b0;
  logic [AL-1:0] m_vld = '0;
  logic [VW-1:0] m_dat [AL];
  initial for (int i = 0; i < AL; i++) m_dat[i] = '0;
  always @(posedge clk) begin
    m_vld    <= {m_vld[AL-2:0], act_vld};
    m_dat[0] <= relu(act_data);
    for (int i = 1; i < AL; i++) m_dat[i] <= m_dat[i-1];
  end
  assign act_res_vld  = m_vld[AL-1] | inj;
  assign act_res_data = m_dat[AL-1];

  typedef struct { logic [VW-1:0] data; logic last; } beat_t;
  typedef struct { int id; logic rel; } exp_t;
  typedef struct { int id; logic [VW-1:0] data; logic last; int due; } sb_t;

  beat_t rq [NR][$];
  exp_t  exp_q [$];
  sb_t   sb [$];
  int    checks = 0, failures = 0, cyc = 0, m_ptr = 0;
  logic  rel_pend = 1'b0;

  task automatic chk(input logic [1023:0] obs, input logic [1023:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic chk_all_zero(input string p);
    chk(req_rdy, 0, {p, "_req_rdy"});
    chk(act_vld, 0, {p, "_act_vld"});
    chk(act_data, 0, {p, "_act_data"});
    chk(rsp_vld, 0, {p, "_rsp_vld"});
    chk(rsp_last, 0, {p, "_rsp_last"});
    chk(rsp_data, 0, {p, "_rsp_data"});
    chk(grant_id, 0, {p, "_grant_id"});
    chk(busy, 0, {p, "_busy"});
    chk(err_orphan, 0, {p, "_err_orphan"});
  endtask

  task automatic push_pkt(input int id, input int n, input bit rnd);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < VW / 32; w++) b.data[w*32 +: 32] = $urandom;
      if (!rnd) b.data[DW-1:0] = DW'(id * 16 + k);
      b.last = (k == n - 1);
      rq[id].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_vld[i]  = (rq[i].size() > 0);
      req_last[i] = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
      req_data[i*VW +: VW] = (rq[i].size() > 0) ? rq[i][0].data : '0;
    end
  endtask

  // Reference: walk all queued beats round-robin from the pointer, bursts capped at MB.
  task automatic build_exp();
    int idx [NR];
    int g, n;
    logic rel;
    for (int i = 0; i < NR; i++) idx[i] = 0;
    forever begin
      g = -1;
      for (int k = 0; k < NR; k++)
        if (g < 0 && idx[(m_ptr + k) % NR] < rq[(m_ptr + k) % NR].size()) g = (m_ptr + k) % NR;
      if (g < 0) break;
      n = 0;
      do begin
        rel = rq[g][idx[g]].last;
        idx[g]++; n++;
        rel = rel || (n == MB) || (idx[g] >= rq[g].size());
        exp_q.push_back('{g, rel});
      end while (!rel);
      m_ptr = (g + 1) % NR;
    end
  endtask

  task automatic step();
    int g;
    logic [NR-1:0] acc;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk(rsp_vld, NR'(1) << sb[0].id, "rsp_route");
      chk(rsp_data, sb[0].data, "rsp_data");
      chk(rsp_last, sb[0].last, "rsp_last");
      $display("rsp id=%0d last=%0b cyc=%0d", sb[0].id, sb[0].last, cyc);
      void'(sb.pop_front());
    end else begin
      chk(rsp_vld, 0, "rsp_idle");
    end
    if (rel_pend) begin
      chk(req_rdy, 0, "dead_cycle");
      rel_pend = 1'b0;
    end
    acc = req_rdy & req_vld;
    g = -1;
    for (int i = 0; i < NR; i++) if (acc[i]) g = i;
    if (g >= 0) begin
      if (exp_q.size() == 0) chk(g, NR, "unexpected_accept");
      else begin
        chk(g, exp_q[0].id, "grant_order");
        chk(busy, 1, "busy_grant");
        sb.push_back('{g, relu(rq[g][0].data), rq[g][0].last, cyc + 2 + AL});
        rel_pend = exp_q[0].rel;
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (g >= 0 && rq[g].size() > 0) void'(rq[g].pop_front());
    drive();
  endtask

  task automatic run(input string name);
    int n = 0;
    build_exp();
    drive();
    while ((exp_q.size() > 0 || sb.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    chk(n < 3000, 1, {name, "_timeout"});
    exp_q.delete();
    sb.delete();
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive();
    step();
    chk(busy, 0, {name, "_busy_drained"});
    chk(err_orphan, 0, {name, "_no_orphan"});
    $display("scenario %s done cyc=%0d", name, cyc);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    req_vld = '0; req_last = '0; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    m_ptr = 0;

    push_pkt(0, 3, 0);
    run("single_req0");

    push_pkt(0, 1, 0); push_pkt(0, 1, 0);
    push_pkt(1, 1, 0); push_pkt(2, 1, 0); push_pkt(3, 1, 0);
    run("all_single");

    push_pkt(2, 20, 1);
    push_pkt(1, 2, 1); push_pkt(1, 2, 1);
    run("burst_cap");

    push_pkt(0, 5, 0); push_pkt(0, 3, 0);
    push_pkt(3, 5, 0); push_pkt(3, 2, 0);
    run("alt_0_3");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NR; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) push_pkt(i, $urandom_range(1, 12), 1);
      end
      run("random");
    end

    // Reset with results still in the activation unit.
    push_pkt(0, 2, 0);
    build_exp();
    drive();
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin step(); n++; end
    chk(n < 20, 1, "rst_fill_timeout");
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_q.delete(); sb.delete(); rel_pend = 1'b0; m_ptr = 0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    @(negedge clk);
    reset_n = 1'b1;
    drive();
    repeat (10) step();
    chk(err_orphan, 1, "stale_orphan");

    reset_n = 1'b0;
    @(negedge clk);
    chk(err_orphan, 0, "orphan_cleared");
    reset_n = 1'b1;
    m_ptr = 0;
    repeat (2) step();
    chk(err_orphan, 0, "orphan_quiet");
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk(err_orphan, 1, "orphan_set");
    repeat (5) step();
    chk(err_orphan, 1, "orphan_sticky");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
